rv32_fetch: RTL and testbench

- Instruction fetch stage: the producer side of the fetch→decode pipeline interface.
- Generates PCs and issues reads on the instruction bus.
- Statically predicts branches and JAL (backward-taken / forward-not-taken).
- Registers pc/instr/valid/exception/prediction toward decode, honouring the hazard unit's stall/flush and execute-stage redirects; a one-entry skid buffer absorbs a bus response that lands during a stall.

---
 rtl/rv32_fetch_if.sv | 19 +
 rtl/rv32_fetch.sv | 149 ++++++++++++++
 tb/tb_rv32_fetch.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/rv32_fetch_if.sv
// Instruction-bus bundle between the fetch stage (master) and instruction memory (slave).
// One request at a time: a transfer completes when read and ready are both high.
interface rv32_fetch_if;
  logic [31:0] instr_address_out;
  logic        instr_read_out;
  logic        instr_ready_in;
  logic [31:0] instr_read_value_in;
  logic        instr_fault_in;

  modport master (
    output instr_address_out, instr_read_out,
    input  instr_ready_in, instr_read_value_in, instr_fault_in
  );

  modport slave (
    input  instr_address_out, instr_read_out,
    output instr_ready_in, instr_read_value_in, instr_fault_in
  );
endinterface

// File: rtl/rv32_fetch.sv
// RV32 fetch with static BTFN/JAL prediction; decode sees a word one cycle after its bus transfer.
// stall_in holds the output register; a response landing during a stall parks in a one-entry skid that blocks further requests.
module rv32_fetch #(
  parameter logic [31:0] RESET_VECTOR   = 32'h00000000,
  parameter bit          PREDICT_ENABLE = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_in,
  input  logic               flush_in,
  input  logic               redirect_in,
  input  logic [31:0]        redirect_pc_in,
  rv32_fetch_if.master       bus,
  output logic               valid_out,
  output logic               exception_out,
  output logic [3:0]         exception_cause_out,
  output logic               branch_predicted_taken_out,
  output logic [31:0]        pc_out,
  output logic [31:0]        instr_out
);
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [0:0] {FETCH, KILL} state_t;

  typedef struct packed {
    logic        exc;
    logic [3:0]  cause;
    logic        pred;
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t      state, state_next;
  logic [31:0] fetch_pc, kill_addr;
  logic        halted, skid_full;
  entry_t      skid, new_entry;
  logic        new_vld, xfer, misaligned, pred_taken;
  logic [31:0] w, bimm, jimm, next_pc;

  assign misaligned = (fetch_pc[1:0] != 2'b00);
  assign bus.instr_read_out = !reset && !halted && !skid_full &&
                              (state == KILL || !misaligned);
  assign bus.instr_address_out = reset ? 32'h0 : ((state == KILL) ? kill_addr : fetch_pc);
  assign xfer = bus.instr_read_out && bus.instr_ready_in;

  assign w    = bus.instr_read_value_in;
  assign bimm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
  assign jimm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};

  always_comb begin
    pred_taken = 1'b0;
    next_pc    = fetch_pc + 32'd4;
    if (PREDICT_ENABLE && !bus.instr_fault_in) begin
      if (w[6:0] == 7'b1100011 && w[31]) begin
        pred_taken = 1'b1;
        next_pc    = fetch_pc + bimm;
      end else if (w[6:0] == 7'b1101111) begin
        pred_taken = 1'b1;
        next_pc    = fetch_pc + jimm;
      end
    end
  end

  // New decode entry: a live response, or a synthesized misaligned-PC exception.
  always_comb begin
    new_vld   = 1'b0;
    new_entry = '{exc: 1'b0, cause: 4'd0, pred: 1'b0, pc: fetch_pc, instr: NOP};
    if (state == FETCH && !redirect_in) begin
      if (xfer) begin
        new_vld = 1'b1;
        if (bus.instr_fault_in) begin
          new_entry.exc   = 1'b1;
          new_entry.cause = 4'd1;
        end else begin
          new_entry.instr = w;
          new_entry.pred  = pred_taken;
        end
      end else if (misaligned && !halted && !skid_full) begin
        new_vld       = 1'b1;
        new_entry.exc = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH: if (redirect_in && bus.instr_read_out && !bus.instr_ready_in) state_next = KILL;
      KILL:  if (xfer) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc                   <= RESET_VECTOR;
      kill_addr                  <= 32'h0;
      halted                     <= 1'b0;
      skid_full                  <= 1'b0;
      skid                       <= '0;
      valid_out                  <= 1'b0;
      exception_out              <= 1'b0;
      exception_cause_out        <= 4'd0;
      branch_predicted_taken_out <= 1'b0;
      pc_out                     <= 32'h0;
      instr_out                  <= NOP;
    end else begin
      if (redirect_in) begin
        fetch_pc  <= redirect_pc_in;
        halted    <= 1'b0;
        skid_full <= 1'b0;
        if (state == FETCH && bus.instr_read_out && !bus.instr_ready_in)
          kill_addr <= fetch_pc;
      end else begin
        if (new_vld) begin
          if (xfer) fetch_pc <= next_pc;
          if (new_entry.exc) halted <= 1'b1;
        end
        if (new_vld && stall_in) begin
          skid      <= new_entry;
          skid_full <= 1'b1;
        end else if (!stall_in && !flush_in && skid_full) begin
          skid_full <= 1'b0;
        end
      end

      if (!stall_in) begin
        if (!flush_in && (skid_full || new_vld)) begin
          valid_out                  <= 1'b1;
          exception_out              <= skid_full ? skid.exc   : new_entry.exc;
          exception_cause_out        <= skid_full ? skid.cause : new_entry.cause;
          branch_predicted_taken_out <= skid_full ? skid.pred  : new_entry.pred;
          pc_out                     <= skid_full ? skid.pc    : new_entry.pc;
          instr_out                  <= skid_full ? skid.instr : new_entry.instr;
        end else begin
          valid_out                  <= 1'b0;
          exception_out              <= 1'b0;
          exception_cause_out        <= 4'd0;
          branch_predicted_taken_out <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_rv32_fetch.sv
// Directed bench for rv32_fetch: zero-wait memory model plus hand-computed expectations.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_rv32_fetch;
  logic        clk = 1'b0;
  logic        reset, stall_in, flush_in, redirect_in, rdy, flt;
  logic [31:0] redirect_pc_in;
  logic        valid_out, exception_out, branch_predicted_taken_out;
  logic [3:0]  exception_cause_out;
  logic [31:0] pc_out, instr_out;
  int          n_checks = 0;
  int          n_fail   = 0;

  rv32_fetch_if bus ();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h300: mem_word = 32'hDEADBEEF;
      32'h500: mem_word = 32'hFE000EE3;
      32'h600: mem_word = 32'h0080006F;
      default: mem_word = 32'h00000013;
    endcase
  endfunction

  assign bus.instr_ready_in      = rdy;
  assign bus.instr_fault_in      = flt;
  assign bus.instr_read_value_in = mem_word(bus.instr_address_out);

  rv32_fetch #(.RESET_VECTOR(32'h100), .PREDICT_ENABLE(1'b1)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .stall_in                   (stall_in),
    .flush_in                   (flush_in),
    .redirect_in                (redirect_in),
    .redirect_pc_in             (redirect_pc_in),
    .bus                        (bus.master),
    .valid_out                  (valid_out),
    .exception_out              (exception_out),
    .exception_cause_out        (exception_cause_out),
    .branch_predicted_taken_out (branch_predicted_taken_out),
    .pc_out                     (pc_out),
    .instr_out                  (instr_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_in    = 1'b1;
    flush_in       = 1'b1;
    redirect_pc_in = pc;
    tick();
    redirect_in    = 1'b0;
    flush_in       = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0; redirect_in = 1'b0;
    redirect_pc_in = 32'h0; rdy = 1'b1; flt = 1'b0;
    tick(); tick();
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_instr", instr_out, 32'h13);
    check("rst_pc", pc_out, 32'h0);
    check("rst_read", {31'd0, bus.instr_read_out}, 32'd0);
    reset = 1'b0;
    #1;
    check("boot_addr0", bus.instr_address_out, 32'h100);
    check("boot_read0", {31'd0, bus.instr_read_out}, 32'd1);
    tick();
    check("boot_addr1", bus.instr_address_out, 32'h104);
    check("boot_pc0", pc_out, 32'h100);
    check("boot_valid0", {31'd0, valid_out}, 32'd1);
    check("boot_pred0", {31'd0, branch_predicted_taken_out}, 32'd0);
    tick();
    check("boot_addr2", bus.instr_address_out, 32'h108);
    check("boot_pc1", pc_out, 32'h104);

    // Response to 0x200 lands in the first stalled cycle and parks in the skid.
    redirect_to(32'h200);
    check("stall_addr", bus.instr_address_out, 32'h200);
    stall_in = 1'b1;
    tick();
    check("stall_read1", {31'd0, bus.instr_read_out}, 32'd0);
    check("stall_valid1", {31'd0, valid_out}, 32'd0);
    tick();
    check("stall_read2", {31'd0, bus.instr_read_out}, 32'd0);
    tick();
    stall_in = 1'b0;
    #1;
    check("drain_read", {31'd0, bus.instr_read_out}, 32'd0);
    tick();
    check("drain_pc", pc_out, 32'h200);
    check("drain_valid", {31'd0, valid_out}, 32'd1);
    check("resume_read", {31'd0, bus.instr_read_out}, 32'd1);
    check("resume_addr", bus.instr_address_out, 32'h204);

    // Redirect while a request is pending drains it through KILL.
    redirect_to(32'h300);
    rdy = 1'b0;
    tick(); tick();
    check("wait_addr", bus.instr_address_out, 32'h300);
    check("wait_valid", {31'd0, valid_out}, 32'd0);
    redirect_to(32'h400);
    check("kill_addr0", bus.instr_address_out, 32'h300);
    check("kill_read0", {31'd0, bus.instr_read_out}, 32'd1);
    tick();
    check("kill_addr1", bus.instr_address_out, 32'h300);
    rdy = 1'b1;
    tick();
    check("kill_discard", {31'd0, valid_out}, 32'd0);
    check("kill_next", bus.instr_address_out, 32'h400);
    tick();
    check("post_kill_pc", pc_out, 32'h400);
    check("post_kill_valid", {31'd0, valid_out}, 32'd1);

    // Backward branch and forward JAL are both predicted taken.
    redirect_to(32'h500);
    tick();
    check("beq_pc", pc_out, 32'h500);
    check("beq_instr", instr_out, 32'hFE000EE3);
    check("beq_pred", {31'd0, branch_predicted_taken_out}, 32'd1);
    check("beq_target", bus.instr_address_out, 32'h4FC);
    redirect_to(32'h600);
    tick();
    check("jal_pred", {31'd0, branch_predicted_taken_out}, 32'd1);
    check("jal_target", bus.instr_address_out, 32'h608);
    tick();
    check("nop_pred", {31'd0, branch_predicted_taken_out}, 32'd0);
    check("nop_pc", pc_out, 32'h608);

    // Misaligned PC raises cause 0 without touching the bus.
    redirect_to(32'h702);
    check("mis_read0", {31'd0, bus.instr_read_out}, 32'd0);
    tick();
    check("mis_valid", {31'd0, valid_out}, 32'd1);
    check("mis_exc", {31'd0, exception_out}, 32'd1);
    check("mis_cause", {28'd0, exception_cause_out}, 32'd0);
    check("mis_pc", pc_out, 32'h702);
    check("mis_instr", instr_out, 32'h13);
    check("mis_pred", {31'd0, branch_predicted_taken_out}, 32'd0);
    tick();
    check("mis_halt_read", {31'd0, bus.instr_read_out}, 32'd0);
    check("mis_halt_valid", {31'd0, valid_out}, 32'd0);
    redirect_to(32'h800);
    check("unhalt_read", {31'd0, bus.instr_read_out}, 32'd1);
    check("unhalt_addr", bus.instr_address_out, 32'h800);

    // Bus access fault raises cause 1 and halts until the next redirect.
    redirect_to(32'h900);
    flt = 1'b1;
    tick();
    flt = 1'b0;
    check("flt_valid", {31'd0, valid_out}, 32'd1);
    check("flt_exc", {31'd0, exception_out}, 32'd1);
    check("flt_cause", {28'd0, exception_cause_out}, 32'd1);
    check("flt_pc", pc_out, 32'h900);
    check("flt_instr", instr_out, 32'h13);
    check("flt_read0", {31'd0, bus.instr_read_out}, 32'd0);
    tick();
    check("flt_read1", {31'd0, bus.instr_read_out}, 32'd0);
    redirect_to(32'hA00);
    check("flt_clear_read", {31'd0, bus.instr_read_out}, 32'd1);
    check("flt_clear_addr", bus.instr_address_out, 32'hA00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
